zl_dvb_s_derand: RTL



---
 rtl/zl_dvb_s_derand.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/zl_dvb_s_derand.sv
// DVB-S receive energy-dispersal removal: superframe lock on the inverted sync byte,
// PRBS derandomisation, sync restoration and a single-register req/ack output stage.
module zl_dvb_s_derand #(
   parameter int unsigned PKT_LEN  = 188,
   parameter int unsigned MISS_MAX = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       data_in_req,
   output logic       data_in_ack,
   output logic [7:0] data_out,
   output logic       data_out_sop,
   output logic       data_out_req,
   input  logic       data_out_ack,
   output logic       locked
);

   localparam int unsigned POS_W   = $clog2(PKT_LEN);
   localparam int unsigned MISS_W  = 4;
   localparam int unsigned PRBS_W  = 15;
   localparam logic [PRBS_W-1:0] PRBS_INIT = 15'h00A9;
   localparam logic [7:0] SYNC     = 8'h47;
   localparam logic [7:0] SYNC_INV = 8'hB8;

   if (MISS_MAX < 1 || MISS_MAX > 15) begin : g_bad_miss
      $error("MISS_MAX must be in 1..15");
   end
   if (PKT_LEN < 2) begin : g_bad_len
      $error("PKT_LEN must be at least 2");
   end

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Advance the 1+x^14+x^15 generator by eight bits; first feedback bit lands in the MSB.
   function automatic logic [PRBS_W+7:0] prbs_byte(input logic [PRBS_W-1:0] r_in);
      logic [PRBS_W-1:0] r;
      logic [7:0]        b;
      logic              fb;
      r = r_in;
      b = '0;
      for (int i = 0; i < 8; i++) begin
         fb = r[13] ^ r[14];
         b  = {b[6:0], fb};
         r  = {r[13:0], fb};
      end
      return {r, b};
   endfunction

   state_t              state, state_nx;
   logic [POS_W-1:0]    pos, pos_nx, pos_inc;
   logic [2:0]          pkt, pkt_nx, pkt_inc;
   logic [MISS_W-1:0]   miss, miss_nx;
   logic [PRBS_W-1:0]   prbs, prbs_nx;
   logic [PRBS_W+7:0]   prbs_step;
   logic [7:0]          dout_nx;
   logic                sop_nx;
   logic                req_nx;
   logic                locked_nx;
   logic                ack_en;
   logic                xfer;
   logic                pos_last;
   logic [7:0]          sync_exp;
   logic                sync_good;

   // Free-running discard while hunting; back-pressure only once bytes are forwarded.
   assign data_in_ack = ack_en && ((state != LOCKED) || !data_out_req || data_out_ack);
   assign xfer        = data_in_req && data_in_ack;

   assign pos_last  = (pos == POS_W'(PKT_LEN - 1));
   assign pos_inc   = pos_last ? '0 : pos + POS_W'(1);
   assign pkt_inc   = pos_last ? pkt + 3'd1 : pkt;
   assign sync_exp  = (pkt == 3'd0) ? SYNC_INV : SYNC;
   assign sync_good = (data_in == sync_exp);
   assign prbs_step = prbs_byte(prbs);

   // Next-state, counters, PRBS and output-register loading.
   always_comb begin
      state_nx  = state;
      pos_nx    = pos;
      pkt_nx    = pkt;
      miss_nx   = miss;
      prbs_nx   = prbs;
      dout_nx   = data_out;
      sop_nx    = data_out_sop;
      req_nx    = data_out_req && !data_out_ack;
      locked_nx = locked;

      if (xfer) begin
         case (state)
            SEARCH: begin
               if (data_in == SYNC_INV) begin
                  state_nx = VERIFY;
                  pos_nx   = POS_W'(1);
                  pkt_nx   = 3'd0;
               end
            end

            VERIFY: begin
               pos_nx = pos_inc;
               pkt_nx = pkt_inc;
               if (pos == '0) begin
                  if (sync_good && pkt == 3'd0) begin
                     state_nx  = LOCKED;
                     prbs_nx   = PRBS_INIT;
                     miss_nx   = '0;
                     locked_nx = 1'b1;
                     dout_nx   = SYNC;
                     sop_nx    = 1'b1;
                     req_nx    = 1'b1;
                  end else if (!sync_good && data_in == SYNC_INV) begin
                     pos_nx = POS_W'(1);
                     pkt_nx = 3'd0;
                  end else if (!sync_good) begin
                     state_nx = SEARCH;
                     pos_nx   = '0;
                     pkt_nx   = 3'd0;
                  end
               end
            end

            LOCKED: begin
               pos_nx = pos_inc;
               pkt_nx = pkt_inc;
               if (pos == '0) begin
                  // Sync slots never consume a scrambling byte but keep the generator in step.
                  prbs_nx = (pkt == 3'd0) ? PRBS_INIT : prbs_step[PRBS_W+7:8];
                  if (!sync_good && miss == MISS_W'(MISS_MAX - 1)) begin
                     state_nx  = SEARCH;
                     locked_nx = 1'b0;
                     miss_nx   = '0;
                     pos_nx    = '0;
                     pkt_nx    = 3'd0;
                     prbs_nx   = PRBS_INIT;
                  end else begin
                     miss_nx = sync_good ? '0 : miss + MISS_W'(1);
                     dout_nx = SYNC;
                     sop_nx  = 1'b1;
                     req_nx  = 1'b1;
                  end
               end else begin
                  prbs_nx = prbs_step[PRBS_W+7:8];
                  dout_nx = data_in ^ prbs_step[7:0];
                  sop_nx  = 1'b0;
                  req_nx  = 1'b1;
               end
            end

            default: begin
               state_nx = SEARCH;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= SEARCH;
         pos          <= '0;
         pkt          <= 3'd0;
         miss         <= '0;
         prbs         <= PRBS_INIT;
         data_out     <= 8'h00;
         data_out_sop <= 1'b0;
         data_out_req <= 1'b0;
         locked       <= 1'b0;
         ack_en       <= 1'b0;
      end else begin
         state        <= state_nx;
         pos          <= pos_nx;
         pkt          <= pkt_nx;
         miss         <= miss_nx;
         prbs         <= prbs_nx;
         data_out     <= dout_nx;
         data_out_sop <= sop_nx;
         data_out_req <= req_nx;
         locked       <= locked_nx;
         ack_en       <= 1'b1;
      end
   end

endmodule
